mem_fill_arbiter: RTL and testbench

Arbiter and fill sequencer between the two caches' fill FSMs (I-cache, D-cache) and the single-ported, pipelined main memory. It grants the memory port to one cache for one complete 8-word block fill and forwards that cache's sequential word addresses to memory. It routes returning read data and valid strobes only to the owning cache, and drives each cache's wait (stall) input while the other cache holds the port. It sits directly downstream of each cache's miss/fill logic and upstream of main memory.

---
 rtl/mem_fill_arbiter_pkg.sv | 19 +
 rtl/mem_fill_arbiter_fill_counter.sv | 25 ++
 rtl/mem_fill_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_fill_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_fill_arbiter_pkg.sv
// Shared definitions for the cache fill arbiter: state encoding and default geometry.
package mem_fill_arbiter_pkg;

    localparam int ADDR_W_DEF          = 16;
    localparam int DATA_W_DEF          = 16;
    localparam int WORDS_PER_BLOCK_DEF = 8;
    localparam int MEM_LATENCY_DEF     = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        SERVE_D = 2'b01,
        SERVE_I = 2'b10
    } arb_state_t;

    function automatic int cnt_width(input int words);
        return $clog2(words) + 1;
    endfunction

endpackage

// File: rtl/mem_fill_arbiter_fill_counter.sv
// Clearable, enabled up-counter with a terminal-value flag; one tracks issued words, one returned words.
module mem_fill_arbiter_fill_counter #(
    parameter int WIDTH    = 4,
    parameter int TERMINAL = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign terminal = (count == WIDTH'(TERMINAL));

endmodule

// File: rtl/mem_fill_arbiter.sv
// Grants the single memory port to one cache per 8-word block fill and routes returns to the owner.
module mem_fill_arbiter
    import mem_fill_arbiter_pkg::*;
#(
    parameter int ADDR_W          = ADDR_W_DEF,
    parameter int DATA_W          = DATA_W_DEF,
    parameter int WORDS_PER_BLOCK = WORDS_PER_BLOCK_DEF,
    parameter int MEM_LATENCY     = MEM_LATENCY_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              icache_miss,
    input  logic [ADDR_W-1:0] icache_addr,
    input  logic              dcache_miss,
    input  logic [ADDR_W-1:0] dcache_addr,
    output logic              wait_icache,
    output logic              wait_dcache,
    output logic              mem_enable,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data_in,
    input  logic              mem_data_valid_in,
    output logic              icache_data_valid,
    output logic              dcache_data_valid,
    output logic [DATA_W-1:0] fill_data
);

    localparam int CNT_W = cnt_width(WORDS_PER_BLOCK);

    if (MEM_LATENCY < 1 || WORDS_PER_BLOCK < 2) begin : g_bad_cfg
        $error("mem_fill_arbiter: MEM_LATENCY must be >= 1 and WORDS_PER_BLOCK >= 2");
    end

    arb_state_t state;
    arb_state_t state_next;
    logic       last_owner;
    logic       serve_d;
    logic       serve_i;
    logic       issue_full;
    logic       ret_last;
    logic       ret_en;
    logic       fill_done;

    assign serve_d   = (state == SERVE_D);
    assign serve_i   = (state == SERVE_I);
    assign ret_en    = mem_data_valid_in && (serve_d || serve_i);
    assign fill_done = ret_en && ret_last;

    mem_fill_arbiter_fill_counter #(.WIDTH(CNT_W), .TERMINAL(WORDS_PER_BLOCK)) u_issue_cnt (
        .clk      (clk),
        .rst      (rst),
        .clear    (fill_done),
        .enable   (mem_enable),
        .terminal (issue_full)
    );

    mem_fill_arbiter_fill_counter #(.WIDTH(CNT_W), .TERMINAL(WORDS_PER_BLOCK - 1)) u_ret_cnt (
        .clk      (clk),
        .rst      (rst),
        .clear    (fill_done),
        .enable   (ret_en),
        .terminal (ret_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_owner <= 1'b0;
        end else begin
            state <= state_next;
            if (fill_done) begin
                last_owner <= serve_i;
            end
        end
    end

    // On completion the other cache gets priority, which guarantees D/I alternation under contention.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (dcache_miss) begin
                    state_next = SERVE_D;
                end else if (icache_miss) begin
                    state_next = SERVE_I;
                end
            end
            SERVE_D: begin
                if (fill_done) begin
                    if (icache_miss) begin
                        state_next = SERVE_I;
                    end else if (dcache_miss) begin
                        state_next = SERVE_D;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            SERVE_I: begin
                if (fill_done) begin
                    if (dcache_miss) begin
                        state_next = SERVE_D;
                    end else if (icache_miss) begin
                        state_next = SERVE_I;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign mem_enable        = (serve_d || serve_i) && !issue_full;
    assign mem_addr          = mem_enable ? (serve_i ? icache_addr : dcache_addr) : '0;
    assign icache_data_valid = mem_data_valid_in && serve_i;
    assign dcache_data_valid = mem_data_valid_in && serve_d;
    assign fill_data         = mem_data_in;
    assign wait_icache       = icache_miss && !serve_i;
    assign wait_dcache       = dcache_miss && !serve_d;

    a_alternate: assert property (@(posedge clk) disable iff (rst)
        (fill_done && serve_d && icache_miss) |=> (state == SERVE_I && !last_owner));

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Directed bench for mem_fill_arbiter with a fixed-latency pipelined memory model driven from tick().
module tb_mem_fill_arbiter;
    import mem_fill_arbiter_pkg::*;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              icache_miss = 1'b0;
    logic [ADDR_W-1:0] icache_addr = '0;
    logic              dcache_miss = 1'b0;
    logic [ADDR_W-1:0] dcache_addr = '0;
    logic              wait_icache;
    logic              wait_dcache;
    logic              mem_enable;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_in = '0;
    logic              mem_data_valid_in = 1'b0;
    logic              icache_data_valid;
    logic              dcache_data_valid;
    logic [DATA_W-1:0] fill_data;

    logic [3:0]        pipe = '0;
    logic              extra_valid = 1'b0;
    logic [DATA_W-1:0] ret_word = 16'hA500;
    int                check_cnt = 0;
    int                pass_cnt = 0;

    mem_fill_arbiter dut (
        .clk               (clk),
        .rst               (rst),
        .icache_miss       (icache_miss),
        .icache_addr       (icache_addr),
        .dcache_miss       (dcache_miss),
        .dcache_addr       (dcache_addr),
        .wait_icache       (wait_icache),
        .wait_dcache       (wait_dcache),
        .mem_enable        (mem_enable),
        .mem_addr          (mem_addr),
        .mem_data_in       (mem_data_in),
        .mem_data_valid_in (mem_data_valid_in),
        .icache_data_valid (icache_data_valid),
        .dcache_data_valid (dcache_data_valid),
        .fill_data         (fill_data)
    );

    always #5 clk = ~clk;

    // One clock: memory sees this cycle's issue and returns it MEM_LATENCY cycles later.
    task automatic tick();
        logic en;
        en = (mem_enable === 1'b1);
        @(posedge clk);
        #1;
        pipe              = {pipe[2:0], en};
        mem_data_valid_in = pipe[3] | extra_valid;
        ret_word          = ret_word + 16'd1;
        mem_data_in       = ret_word;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; icache_miss = 1'b1; dcache_miss = 1'b0;
        tick(); tick();
        check_cnt++; if (mem_enable !== 1'b0) $display("[TB] FAIL reset_mem_enable got %0b want 0", mem_enable); else pass_cnt++;
        check_cnt++; if (mem_addr !== 16'h0000) $display("[TB] FAIL reset_mem_addr got %0h want 0", mem_addr); else pass_cnt++;
        check_cnt++; if (icache_data_valid !== 1'b0 || dcache_data_valid !== 1'b0)
            $display("[TB] FAIL reset_data_valid got i=%0b d=%0b want 0/0", icache_data_valid, dcache_data_valid); else pass_cnt++;
        check_cnt++; if (wait_icache !== 1'b1) $display("[TB] FAIL reset_wait_icache got %0b want 1", wait_icache); else pass_cnt++;
        check_cnt++; if (wait_dcache !== 1'b0) $display("[TB] FAIL reset_wait_dcache got %0b want 0", wait_dcache); else pass_cnt++;
        icache_miss = 1'b0;
        #1;
        check_cnt++; if (wait_icache !== 1'b0) $display("[TB] FAIL reset_wait_follow got %0b want 0", wait_icache); else pass_cnt++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_ifill();
        logic [ADDR_W-1:0] exp_addr;
        icache_miss = 1'b1; icache_addr = 16'h0400;
        tick();
        for (int c = 0; c < 12; c++) begin
            exp_addr = (c < 8) ? ADDR_W'(16'h0400 + 2 * c) : 16'h0000;
            check_cnt++; if (mem_enable !== (c < 8)) $display("[TB] FAIL ifill_enable c=%0d got %0b want %0b", c, mem_enable, (c < 8)); else pass_cnt++;
            check_cnt++; if (mem_addr !== exp_addr) $display("[TB] FAIL ifill_addr c=%0d got %0h want %0h", c, mem_addr, exp_addr); else pass_cnt++;
            check_cnt++; if (icache_data_valid !== (c >= 4)) $display("[TB] FAIL ifill_ivalid c=%0d got %0b want %0b", c, icache_data_valid, (c >= 4)); else pass_cnt++;
            check_cnt++; if (dcache_data_valid !== 1'b0) $display("[TB] FAIL ifill_dvalid c=%0d got %0b want 0", c, dcache_data_valid); else pass_cnt++;
            check_cnt++; if (wait_icache !== 1'b0) $display("[TB] FAIL ifill_wait c=%0d got %0b want 0", c, wait_icache); else pass_cnt++;
            check_cnt++; if (fill_data !== ret_word) $display("[TB] FAIL ifill_data c=%0d got %0h want %0h", c, fill_data, ret_word); else pass_cnt++;
            icache_addr = ADDR_W'(16'h0400 + 2 * (c + 1));
            if (c == 11) icache_miss = 1'b0;
            tick();
        end
        check_cnt++; if (mem_enable !== 1'b0 || icache_data_valid !== 1'b0)
            $display("[TB] FAIL ifill_idle got en=%0b iv=%0b want 0/0", mem_enable, icache_data_valid); else pass_cnt++;
        tick();
    endtask

    task automatic test_simultaneous();
        icache_miss = 1'b1; icache_addr = 16'h0400;
        dcache_miss = 1'b1; dcache_addr = 16'h0800;
        tick();
        for (int c = 0; c < 12; c++) begin
            check_cnt++; if (mem_enable !== (c < 8)) $display("[TB] FAIL sim_d_enable c=%0d got %0b want %0b", c, mem_enable, (c < 8)); else pass_cnt++;
            check_cnt++; if ((c < 8) && mem_addr !== 16'h0800) $display("[TB] FAIL sim_d_addr c=%0d got %0h want 0800", c, mem_addr); else pass_cnt++;
            check_cnt++; if (dcache_data_valid !== (c >= 4) || icache_data_valid !== 1'b0)
                $display("[TB] FAIL sim_d_valid c=%0d got d=%0b i=%0b want %0b/0", c, dcache_data_valid, icache_data_valid, (c >= 4)); else pass_cnt++;
            check_cnt++; if (wait_icache !== 1'b1 || wait_dcache !== 1'b0)
                $display("[TB] FAIL sim_d_wait c=%0d got wi=%0b wd=%0b want 1/0", c, wait_icache, wait_dcache); else pass_cnt++;
            if (c == 11) dcache_miss = 1'b0;
            tick();
        end
        for (int c = 0; c < 12; c++) begin
            check_cnt++; if (mem_enable !== (c < 8)) $display("[TB] FAIL sim_i_enable c=%0d got %0b want %0b", c, mem_enable, (c < 8)); else pass_cnt++;
            check_cnt++; if ((c < 8) && mem_addr !== 16'h0400) $display("[TB] FAIL sim_i_addr c=%0d got %0h want 0400", c, mem_addr); else pass_cnt++;
            check_cnt++; if (icache_data_valid !== (c >= 4) || dcache_data_valid !== 1'b0)
                $display("[TB] FAIL sim_i_valid c=%0d got i=%0b d=%0b want %0b/0", c, icache_data_valid, dcache_data_valid, (c >= 4)); else pass_cnt++;
            check_cnt++; if (wait_icache !== 1'b0) $display("[TB] FAIL sim_i_wait c=%0d got %0b want 0", c, wait_icache); else pass_cnt++;
            if (c == 11) icache_miss = 1'b0;
            tick();
        end
        check_cnt++; if (mem_enable !== 1'b0) $display("[TB] FAIL sim_idle got %0b want 0", mem_enable); else pass_cnt++;
        tick();
    endtask

    task automatic test_alternation();
        logic own_i;
        logic exp_wi;
        logic exp_wd;
        dcache_miss = 1'b1; dcache_addr = 16'h1000;
        icache_miss = 1'b0; icache_addr = 16'h2000;
        tick();
        for (int f = 0; f < 3; f++) begin
            own_i = (f == 1);
            for (int c = 0; c < 12; c++) begin
                exp_wi = icache_miss & ~own_i;
                exp_wd = dcache_miss & own_i;
                check_cnt++; if (mem_enable !== (c < 8)) $display("[TB] FAIL alt_enable f=%0d c=%0d got %0b want %0b", f, c, mem_enable, (c < 8)); else pass_cnt++;
                check_cnt++; if ((c < 8) && mem_addr !== (own_i ? 16'h2000 : 16'h1000))
                    $display("[TB] FAIL alt_addr f=%0d c=%0d got %0h want %0h", f, c, mem_addr, (own_i ? 16'h2000 : 16'h1000)); else pass_cnt++;
                check_cnt++; if (icache_data_valid !== (own_i && c >= 4) || dcache_data_valid !== (!own_i && c >= 4))
                    $display("[TB] FAIL alt_valid f=%0d c=%0d got i=%0b d=%0b", f, c, icache_data_valid, dcache_data_valid); else pass_cnt++;
                check_cnt++; if (wait_icache !== exp_wi || wait_dcache !== exp_wd)
                    $display("[TB] FAIL alt_wait f=%0d c=%0d got wi=%0b wd=%0b want %0b/%0b", f, c, wait_icache, wait_dcache, exp_wi, exp_wd); else pass_cnt++;
                if (f == 0 && c == 2) icache_miss = 1'b1;
                if (f == 1 && c == 11) icache_miss = 1'b0;
                if (f == 2 && c == 11) dcache_miss = 1'b0;
                tick();
            end
        end
        check_cnt++; if (mem_enable !== 1'b0) $display("[TB] FAIL alt_idle got %0b want 0", mem_enable); else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_midfill();
        icache_miss = 1'b1; icache_addr = 16'h0400;
        tick();
        for (int c = 0; c < 7; c++) begin
            check_cnt++; if (icache_data_valid !== (c >= 4)) $display("[TB] FAIL rstmid_ivalid c=%0d got %0b want %0b", c, icache_data_valid, (c >= 4)); else pass_cnt++;
            if (c == 6) begin
                rst = 1'b1; icache_miss = 1'b0;
            end
            tick();
        end
        rst = 1'b0;
        #1;
        for (int c = 7; c < 13; c++) begin
            check_cnt++; if (mem_enable !== 1'b0 || mem_addr !== 16'h0000)
                $display("[TB] FAIL rstmid_mem c=%0d got en=%0b addr=%0h want 0/0", c, mem_enable, mem_addr); else pass_cnt++;
            check_cnt++; if (icache_data_valid !== 1'b0 || dcache_data_valid !== 1'b0)
                $display("[TB] FAIL rstmid_valid c=%0d got i=%0b d=%0b want 0/0", c, icache_data_valid, dcache_data_valid); else pass_cnt++;
            check_cnt++; if (wait_icache !== 1'b0 || wait_dcache !== 1'b0)
                $display("[TB] FAIL rstmid_wait c=%0d got wi=%0b wd=%0b want 0/0", c, wait_icache, wait_dcache); else pass_cnt++;
            tick();
        end
    endtask

    task automatic test_miss_drop();
        icache_miss = 1'b1; icache_addr = 16'h0600;
        tick();
        for (int c = 0; c < 12; c++) begin
            check_cnt++; if (mem_enable !== (c < 8)) $display("[TB] FAIL drop_enable c=%0d got %0b want %0b", c, mem_enable, (c < 8)); else pass_cnt++;
            check_cnt++; if (icache_data_valid !== (c >= 4)) $display("[TB] FAIL drop_ivalid c=%0d got %0b want %0b", c, icache_data_valid, (c >= 4)); else pass_cnt++;
            if (c == 1) icache_miss = 1'b0;
            tick();
        end
        for (int c = 12; c < 14; c++) begin
            check_cnt++; if (mem_enable !== 1'b0 || icache_data_valid !== 1'b0)
                $display("[TB] FAIL drop_idle c=%0d got en=%0b iv=%0b want 0/0", c, mem_enable, icache_data_valid); else pass_cnt++;
            tick();
        end
    endtask

    task automatic test_stale_valid();
        extra_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_cnt++; if (icache_data_valid !== 1'b0 || dcache_data_valid !== 1'b0 || mem_enable !== 1'b0)
                $display("[TB] FAIL stale_route c=%0d got i=%0b d=%0b en=%0b want 0/0/0", c, icache_data_valid, dcache_data_valid, mem_enable); else pass_cnt++;
        end
        extra_valid = 1'b0;
        tick();
        dcache_miss = 1'b1; dcache_addr = 16'h3000;
        tick();
        for (int c = 0; c < 12; c++) begin
            check_cnt++; if (mem_enable !== (c < 8)) $display("[TB] FAIL stale_enable c=%0d got %0b want %0b", c, mem_enable, (c < 8)); else pass_cnt++;
            check_cnt++; if (dcache_data_valid !== (c >= 4)) $display("[TB] FAIL stale_dvalid c=%0d got %0b want %0b", c, dcache_data_valid, (c >= 4)); else pass_cnt++;
            if (c == 11) dcache_miss = 1'b0;
            tick();
        end
        check_cnt++; if (mem_enable !== 1'b0 || dcache_data_valid !== 1'b0)
            $display("[TB] FAIL stale_idle got en=%0b dv=%0b want 0/0", mem_enable, dcache_data_valid); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_ifill();
        test_simultaneous();
        test_alternation();
        test_reset_midfill();
        test_miss_drop();
        test_stale_valid();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

endmodule
